contador_param: RTL

Parametrised synchronous up/down/step/load counter. It is the next generation of the team's 4-bit moded counter. WIDTH, step size and overflow policy are parameters, and cascading uses a synchronous carry chain (ci/co) instead of ripple clocking. The block serves as the counting primitive for wide counters (16 bits and up) and for timers in the same design, all on one clock domain.

---
 rtl/contador_pkg.sv | 11 +
 rtl/contador_nxt.sv | 59 +++++
 rtl/contador_param.sv | 59 +++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter family: operation encodings and the modo type.
package contador_pkg;

    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DOWN = 2'b01,
        MODO_STEP = 2'b10,
        MODO_LOAD = 2'b11
    } modo_t;

endpackage

// File: rtl/contador_nxt.sv
// Combinational next-count and carry/borrow event generator for contador_param.
// The same event feeds both the registered RCO and the combinational cascade carry-out.
module contador_nxt
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3,
    parameter bit          SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       modo_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             evt_o
);

    if (WIDTH < 2) begin : g_bad_width
        $error("contador_nxt: WIDTH must be at least 2");
    end
    if ((STEP < 1) || (STEP >= (1 << WIDTH))) begin : g_bad_step
        $error("contador_nxt: STEP must satisfy 1 <= STEP < 2**WIDTH");
    end

    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    modo_t          modo;
    logic [WIDTH:0] sum;

    assign modo = modo_t'(modo_i);

    // One extra bit so the carry (up) or borrow (down) lands in sum[WIDTH].
    always_comb begin
        sum = {1'b0, q_i};
        case (modo)
            MODO_UP:   sum = {1'b0, q_i} + ONE_W;
            MODO_DOWN: sum = {1'b0, q_i} - ONE_W;
            MODO_STEP: sum = {1'b0, q_i} + STEP_W;
            default:   sum = {1'b0, q_i};
        endcase
    end

    always_comb begin
        q_nxt_o = q_i;
        evt_o   = 1'b0;
        if (modo == MODO_LOAD) begin
            q_nxt_o = d_i;
        end else if (adv_i) begin
            evt_o = sum[WIDTH];
            if (SAT && sum[WIDTH]) begin
                q_nxt_o = (modo == MODO_DOWN) ? '0 : '1;
            end else begin
                q_nxt_o = sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down/step/load counter with synchronous ci/co cascade chain.
// Holds only the count/RCO registers; the arithmetic lives in contador_nxt.
module contador_param
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             ci,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             co
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             rco_q;
    logic             evt;
    logic             adv;

    assign adv = enb & ci;

    contador_nxt #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SAT   (SAT)
    ) u_nxt (
        .q_i     (q_q),
        .modo_i  (modo),
        .d_i     (D),
        .adv_i   (adv),
        .q_nxt_o (q_d),
        .evt_o   (evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else if (enb) begin
            q_q   <= q_d;
            rco_q <= evt;
        end else begin
            rco_q <= 1'b0;
        end
    end

    // Carry-out must ripple combinationally through the whole chain within one cycle.
    assign co  = adv & (modo != MODO_LOAD) & evt;
    assign Q   = q_q;
    assign RCO = rco_q;

endmodule
